// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   Drains a FIFO onto a single UART-style serial line. When enabled and
//   the FIFO reports data, the head word is latched and popped with a
//   one-cycle pulse. The word is then sent as a frame: a start bit (0),
//   DATA_W data bits LSB first, an optional even-parity bit, and a stop
//   bit (1). Each bit lasts CLKS_PER_BIT clocks. All outputs are registered.
//
//   Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
//   bit between the last data bit and the stop bit.
//
// Parameters
//   DATA_W        word width (>= 2)
//   CLKS_PER_BIT  clocks per serial bit, 1..255
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset_n       asynchronous active-low reset
//   enable        1 = start new frames when data is available
//   fifo_empty_n  FIFO holds data; fifo_data is valid while high
//   fifo_data     head-of-FIFO word
//   fifo_pop      one-cycle pulse that advances the FIFO head
//   tx            serial line, idles high
//   busy          high for the whole frame, from the pop through the stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              fifo_empty_n,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [TMR_W-1:0]  timer_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              bit_end;

`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  // Last clock of the current serial bit.
  assign bit_end = (timer_q == TMR_LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Abort any frame at once: the line returns high without a clock.
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      timer_q   <= '0;
      bit_idx_q <= '0;
      fifo_pop  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      fifo_pop <= 1'b0;

      // Bit timer runs in every frame state and wraps at each bit boundary.
      if (state_q != ST_IDLE) begin
        timer_q <= bit_end ? '0 : timer_q + TMR_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          tx <= 1'b1;
          // FIFO flags are only looked at here, so the FIFO has a full frame
          // to update them after a pop and pops can never be back to back.
          if (enable && fifo_empty_n) begin
            shift_q   <= fifo_data;
            fifo_pop  <= 1'b1;
            busy      <= 1'b1;
            timer_q   <= '0;
            bit_idx_q <= '0;
            tx        <= 1'b0;
            state_q   <= ST_START;
`ifdef FIFO_UART_TX_PARITY_EN
            // Even parity of the word just latched; fifo_data may change later.
            parity_q  <= ^fifo_data;
`endif
          end
        end

        ST_START: begin
          if (bit_end) begin
            tx      <= shift_q[0];
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity_q;
              state_q <= ST_PARITY;
`else
              tx      <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              // tx follows the bit that becomes shift_q[0] after this shift.
              shift_q   <= shift_q >> 1;
              tx        <= shift_q[1];
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end

`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            state_q <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (bit_end) begin
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx (DATA_W=6, CLKS_PER_BIT=4). A frame model turns
//   each popped word into the list of line levels it must produce, one entry
//   per clock; a compare process checks tx, busy and fifo_pop against it on
//   every clock. Directed scenarios add hand-computed expectations for frame
//   contents, pop spacing, enable gating and reset behaviour.
//   Define FIFO_UART_TX_PARITY_EN for both bench and RTL to cover parity.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int DATA_W = 6;
  localparam int CPB    = 4;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int          NBITS  = 9;
  localparam int          GAP    = 37;
  localparam int          ZEROS  = 32;
  // Bit i of each vector is the line level of frame bit i (bit 0 = start).
  localparam logic [15:0] EXP_2D = 16'h015A;
  localparam logic [15:0] EXP_01 = 16'h0182;
  localparam logic [15:0] EXP_03 = 16'h0106;
`else
  localparam int          NBITS  = 8;
  localparam int          GAP    = 33;
  localparam int          ZEROS  = 28;
  localparam logic [15:0] EXP_2D = 16'h00DA;
  localparam logic [15:0] EXP_01 = 16'h0082;
  localparam logic [15:0] EXP_03 = 16'h0086;
`endif
  localparam int FRAME = NBITS * CPB;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              fifo_empty_n;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              tx;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  fifo_uart_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .fifo_empty_n (fifo_empty_n),
    .fifo_data    (fifo_data),
    .fifo_pop     (fifo_pop),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  logic exp_line[$];   // remaining line levels of the frame in flight
  logic exp_pop;

  function automatic void load_frame(input logic [DATA_W-1:0] w);
    exp_line.delete();
    for (int k = 0; k < CPB; k++) exp_line.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++)
      for (int k = 0; k < CPB; k++) exp_line.push_back(w[i]);
`ifdef FIFO_UART_TX_PARITY_EN
    for (int k = 0; k < CPB; k++) exp_line.push_back(^w);
`endif
    for (int k = 0; k < CPB; k++) exp_line.push_back(1'b1);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_line.delete();
      exp_pop = 1'b0;
    end else begin
      exp_pop = 1'b0;
      if (exp_line.size() == 0) begin
        if (enable && fifo_empty_n) begin
          load_frame(fifo_data);
          exp_pop = 1'b1;
        end
      end else begin
        void'(exp_line.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_tx",   tx,       (exp_line.size() != 0) ? int'(exp_line[0]) : 1);
      check("cyc_busy", busy,     (exp_line.size() != 0) ? 1 : 0);
      check("cyc_pop",  fifo_pop, exp_pop);
    end
  end

  always @(negedge clk) if (chk_en && fifo_pop) pops++;
  always @(posedge clk) cyc++;

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Returns at the negedge where fifo_pop is seen; at = cycle number.
  task automatic wait_pop(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fifo_pop) begin
        at = cyc;
        return;
      end
    end
    check("pop_timeout", 0, 1);
  endtask

  // Sends one word and samples the middle of every frame bit.
  task automatic run_frame(input logic [DATA_W-1:0] word, output logic [15:0] bits,
                           output logic busy_last, output logic busy_after);
    int p;
    bits       = '0;
    busy_last  = 1'b0;
    busy_after = 1'b1;
    fifo_data    = word;
    fifo_empty_n = 1'b1;
    wait_pop(p);
    fifo_empty_n = 1'b0;
    fifo_data    = DATA_W'($urandom);
    for (int c = 0; c <= FRAME; c++) begin
      if (c % CPB == CPB / 2 && c < FRAME) bits[c / CPB] = tx;
      if (c == FRAME - 1) busy_last = busy;
      if (c == FRAME) busy_after = busy;
      if (c < FRAME) @(negedge clk);
    end
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [15:0] bits;
    logic        bl, ba;
    int          p0, p1, p2, z, cr;

    reset_n      = 1'b0;
    enable       = 1'b0;
    fifo_empty_n = 1'b0;
    fifo_data    = '0;
    @(negedge clk);
    chk_en = 1'b1;
    cycles(2);
    check("rst_tx",   tx,       1);
    check("rst_busy", busy,     0);
    check("rst_pop",  fifo_pop, 0);
    reset_n = 1'b1;

    // Idle with no data for 50 cycles.
    enable = 1'b1;
    p0 = pops;
    cycles(50);
    check("idle_pops", pops - p0, 0);
    check("idle_tx",   tx,        1);

    // Single word 6'h2D.
    p0 = pops;
    run_frame(6'h2D, bits, bl, ba);
    check("frame_2d",      int'(bits), int'(EXP_2D));
    check("frame_busy_end", bl, 1);
    check("frame_busy_off", ba, 0);
    check("frame_2d_pops", pops - p0, 1);

    // Back-to-back words 6'h3F then 6'h00.
    fifo_data    = 6'h3F;
    fifo_empty_n = 1'b1;
    wait_pop(p1);
    fifo_data = 6'h00;
    wait_pop(p2);
    fifo_empty_n = 1'b0;
    check("b2b_gap", p2 - p1, GAP);
    z = 0;
    while (tx == 1'b0 && z < 100) begin
      z++;
      @(negedge clk);
    end
    check("b2b_zeros", z, ZEROS);
    cycles(FRAME);

    // Enable gating.
    enable       = 1'b0;
    fifo_data    = 6'h15;
    fifo_empty_n = 1'b1;
    p0 = pops;
    cycles(20);
    check("en_off_pops", pops - p0, 0);
    enable = 1'b1;
    wait_pop(p1);
    cycles(10);
    enable = 1'b0;
    cycles(FRAME + 10);
    check("en_drop_pops", pops - p0, 1);
    check("en_drop_busy", busy, 0);
    fifo_empty_n = 1'b0;
    enable       = 1'b1;

    // Reset during data bit 3.
    fifo_data    = 6'h2D;
    fifo_empty_n = 1'b1;
    wait_pop(p1);
    repeat (17) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx",   tx,       1);
    check("mid_rst_busy", busy,     0);
    check("mid_rst_pop",  fifo_pop, 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    cr = cyc;
    wait_pop(p2);
    check("rst_repop", p2 - cr, 1);
    fifo_empty_n = 1'b0;
    cycles(FRAME + 5);

    // Parity-sensitive words.
    run_frame(6'h01, bits, bl, ba);
    check("frame_01", int'(bits), int'(EXP_01));
    run_frame(6'h03, bits, bl, ba);
    check("frame_03", int'(bits), int'(EXP_03));

    cycles(5);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
